// File: rtl/ospi_pkg.sv
// Shared definitions for the octal-SPI target: command codes, header size,
// FSM states, status bit positions and small decode helpers.
package ospi_pkg;

   localparam logic [3:0] OSPI_CMD_WRITE  = 4'hA;
   localparam logic [3:0] OSPI_CMD_READ   = 4'h2;
   localparam logic [3:0] OSPI_CMD_STATUS = 4'h5;

   localparam int unsigned HDR_LEN = 8;

   // Bit positions inside the status byte
   localparam int unsigned ST_LAST_OK = 0;
   localparam int unsigned ST_CMD_ERR = 1;
   localparam int unsigned ST_RANGE   = 2;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StDummy,
      StWdata,
      StRdata,
      StStat,
      StDone
   } ospi_state_e;

   function automatic logic cmd_known(input logic [3:0] cmd);
      return cmd inside {OSPI_CMD_WRITE, OSPI_CMD_READ, OSPI_CMD_STATUS};
   endfunction

   // Number of low address bits that wrap for a given size code (sizes above 7 act as 7)
   function automatic int unsigned wrap_bits(input logic [3:0] size);
      if (size > 4'd7) return 9;
      return 32'(size) + 32'd2;
   endfunction

endpackage

// File: rtl/ospi_ram.sv
// Single-port byte RAM: synchronous write, one-cycle synchronous read.
module ospi_ram #(
   parameter int unsigned ADDR_W = 18
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [7:0]        wdata_i,
   output logic [7:0]        rdata_o
);

   logic [7:0] mem_q [2**ADDR_W];
   logic [7:0] rdata_q;

   // Write port and registered read (read-first)
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ospi_target_ram.sv
// Octal-SPI target: decodes an 8-byte header, then runs a write burst, a
// linear/wrapping read burst or a status read against an on-chip byte RAM.
module ospi_target_ram
   import ospi_pkg::*;
#(
   parameter int unsigned DQ_W   = 8,
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned LEN_W  = 24,
   parameter int unsigned DUMMY  = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ncs,
   input  logic [DQ_W-1:0] dq_i,
   output logic [DQ_W-1:0] dq_o,
   output logic            dq_oe,
   output logic            dqs_oe,
   output logic            busy,
   output logic            xfer_done,
   output logic            cmd_err
);

   localparam int unsigned DLY_W = $clog2(DUMMY + 1);

   if (DQ_W != 8) begin : g_bad_dq_w
      $error("ospi_target_ram: DQ_W must be 8");
   end
   if (LEN_W > 24 || LEN_W < 1) begin : g_bad_len_w
      $error("ospi_target_ram: LEN_W must be 1..24");
   end
   if (DUMMY < 1) begin : g_bad_dummy
      $error("ospi_target_ram: DUMMY must be at least 1");
   end
   if (ADDR_W < 1 || ADDR_W > 31) begin : g_bad_addr_w
      $error("ospi_target_ram: ADDR_W must be 1..31");
   end

   ospi_state_e       state_q, state_d;
   logic [2:0]        hdr_cnt_q, hdr_cnt_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [3:0]        size_q, size_d;
   logic [23:0]       len_q, len_d;
   logic [23:0]       addr_q, addr_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [7:0]        status_q, status_d;
   logic              dq_oe_q, dq_oe_d;
   logic              dqs_oe_q, dqs_oe_d;
   logic              xfer_done_q, xfer_done_d;
   logic              cmd_err_q, cmd_err_d;

   logic              ram_we;
   logic [7:0]        ram_rdata;
   logic [31:0]       addr_full;
   logic [ADDR_W-1:0] idx_inc, wrap_mask, idx_next;

   // Address generator: linear increments the whole index, wrap holds the upper bits
   assign addr_full = {addr_q, dq_i[7:0]};
   assign idx_inc   = idx_q + ADDR_W'(1);
   assign wrap_mask = (ADDR_W'(1) << wrap_bits(size_q)) - ADDR_W'(1);
   assign idx_next  = (size_q == 4'd0) ? idx_inc : ((idx_q & ~wrap_mask) | (idx_inc & wrap_mask));

   // Next-state logic for the FSM, header capture, counters and status
   always_comb begin
      state_d     = state_q;
      hdr_cnt_d   = hdr_cnt_q;
      cmd_d       = cmd_q;
      size_d      = size_q;
      len_d       = len_q;
      addr_d      = addr_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      dly_d       = dly_q;
      status_d    = status_q;
      dq_oe_d     = dq_oe_q;
      dqs_oe_d    = dqs_oe_q;
      xfer_done_d = 1'b0;
      cmd_err_d   = 1'b0;
      ram_we      = 1'b0;

      if (ncs) begin
         state_d  = StIdle;
         dq_oe_d  = 1'b0;
         dqs_oe_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // The byte sampled while leaving IDLE is header byte 0
               cmd_d     = dq_i[7:4];
               size_d    = dq_i[3:0];
               hdr_cnt_d = 3'd1;
               state_d   = StHdr;
               if (dq_i[7:4] != OSPI_CMD_STATUS) status_d = '0;
               if (!cmd_known(dq_i[7:4])) begin
                  cmd_err_d            = 1'b1;
                  status_d[ST_CMD_ERR] = 1'b1;
               end
            end
            StHdr: begin
               hdr_cnt_d = hdr_cnt_q + 3'd1;
               if (hdr_cnt_q <= 3'd3) len_d = {len_q[15:0], dq_i[7:0]};
               else addr_d = addr_full[23:0];
               if (hdr_cnt_q == 3'(HDR_LEN - 1)) begin
                  idx_d = addr_full[ADDR_W-1:0];
                  cnt_d = len_q[LEN_W-1:0];
                  dly_d = '0;
                  if (cmd_q == OSPI_CMD_WRITE || cmd_q == OSPI_CMD_READ) begin
                     status_d[ST_RANGE] = |addr_full[31:ADDR_W];
                  end
                  if (!cmd_known(cmd_q) || len_q[LEN_W-1:0] == '0) begin
                     state_d = StDone;
                  end else if (cmd_q == OSPI_CMD_WRITE) begin
                     state_d = StWdata;
                  end else begin
                     state_d  = StDummy;
                     dqs_oe_d = 1'b1;
                  end
               end
            end
            StDummy: begin
               dly_d = dly_q + DLY_W'(1);
               if (dly_q == DLY_W'(DUMMY - 1)) begin
                  // Byte 0 is read from RAM this cycle so it is ready in the first data cycle
                  idx_d   = idx_next;
                  dq_oe_d = 1'b1;
                  state_d = (cmd_q == OSPI_CMD_READ) ? StRdata : StStat;
               end
            end
            StWdata, StRdata, StStat: begin
               if (state_q == StWdata) ram_we = 1'b1;
               if (state_q != StStat) idx_d = idx_next;
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_d     = StDone;
                  xfer_done_d = 1'b1;
                  if (state_q != StStat) status_d[ST_LAST_OK] = 1'b1;
               end
            end
            StDone: begin
               state_d = StDone;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         hdr_cnt_q   <= '0;
         cmd_q       <= '0;
         size_q      <= '0;
         len_q       <= '0;
         addr_q      <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         dly_q       <= '0;
         status_q    <= '0;
         dq_oe_q     <= 1'b0;
         dqs_oe_q    <= 1'b0;
         xfer_done_q <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_cnt_q   <= hdr_cnt_d;
         cmd_q       <= cmd_d;
         size_q      <= size_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         dly_q       <= dly_d;
         status_q    <= status_d;
         dq_oe_q     <= dq_oe_d;
         dqs_oe_q    <= dqs_oe_d;
         xfer_done_q <= xfer_done_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   ospi_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (idx_q),
      .wdata_i (dq_i[7:0]),
      .rdata_o (ram_rdata)
   );

   // Output data: RAM read register during reads, status register during status reads
   always_comb begin
      dq_o = '0;
      if (state_q == StRdata) dq_o = ram_rdata;
      else if (state_q == StStat) dq_o = status_q;
   end

   assign dq_oe     = dq_oe_q;
   assign dqs_oe    = dqs_oe_q;
   assign busy      = (state_q != StIdle);
   assign xfer_done = xfer_done_q;
   assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_ospi_target_ram.sv
// Directed and randomized transactions against a byte-array model of the target.
module tb_ospi_target_ram;

   localparam int unsigned ADDR_W = 18;
   localparam int unsigned DUMMY  = 2;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic       clk = 1'b0;
   logic       reset;
   logic       ncs;
   logic [7:0] dq_i;
   logic [7:0] dq_o;
   logic       dq_oe, dqs_oe, busy, xfer_done, cmd_err;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   logic [7:0] mem_m [int unsigned];
   bit         range_m, err_m, ok_m;
   logic [7:0] pend [$];

   always #5 clk = ~clk;

   ospi_target_ram #(
      .DQ_W   (8),
      .ADDR_W (ADDR_W),
      .LEN_W  (24),
      .DUMMY  (DUMMY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ncs       (ncs),
      .dq_i      (dq_i),
      .dq_o      (dq_o),
      .dq_oe     (dq_oe),
      .dqs_oe    (dqs_oe),
      .busy      (busy),
      .xfer_done (xfer_done),
      .cmd_err   (cmd_err)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit known(input logic [3:0] cmd);
      return (cmd == 4'hA) || (cmd == 4'h2) || (cmd == 4'h5);
   endfunction

   // RAM index of data byte k of a burst
   function automatic int unsigned idx_at(input logic [31:0] addr, input logic [3:0] size,
                                          input int unsigned k);
      int unsigned base, n, w;
      base = addr % DEPTH;
      n    = (size > 4'd7) ? 7 : 32'(size);
      if (n == 0) return (base + k) % DEPTH;
      w = 1 << (n + 2);
      return base - (base % w) + ((base % w + k) % w);
   endfunction

   function automatic logic [7:0] status_exp();
      return {5'b0, range_m, err_m, ok_m};
   endfunction

   task automatic send_hdr(input logic [3:0] cmd, input logic [3:0] size,
                           input int unsigned len, input logic [31:0] addr);
      logic [7:0] hb [8];
      hb[0] = {cmd, size};
      hb[1] = 8'(len >> 16);
      hb[2] = 8'(len >> 8);
      hb[3] = 8'(len);
      hb[4] = addr[31:24];
      hb[5] = addr[23:16];
      hb[6] = addr[15:8];
      hb[7] = addr[7:0];
      if (cmd != 4'h5) begin
         range_m = 1'b0;
         err_m   = 1'b0;
         ok_m    = 1'b0;
      end
      if (!known(cmd)) err_m = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ncs  = 1'b0;
         dq_i = hb[i];
         tick();
         if (i == 0) begin
            check("cmd_err_after_byte0", cmd_err, !known(cmd));
            check("busy_in_hdr", busy, 1'b1);
         end
      end
      if (cmd == 4'hA || cmd == 4'h2) range_m = (addr >> ADDR_W) != 0;
   endtask

   // One complete transaction; cut < len raises ncs after cut write bytes
   task automatic xact(input logic [3:0] cmd, input logic [3:0] size, input int unsigned len,
                       input logic [31:0] addr, input int unsigned cut);
      logic [7:0] b, exp;
      send_hdr(cmd, size, len, addr);
      if (!known(cmd) || len == 0) begin
         check("done_no_drive", {busy, dq_oe, dqs_oe, xfer_done}, 4'b1000);
      end else if (cmd == 4'hA) begin
         for (int k = 0; k < len && k < cut; k++) begin
            b    = (pend.size() > 0) ? pend.pop_front() : 8'($urandom);
            dq_i = b;
            tick();
            mem_m[idx_at(addr, size, k)] = b;
         end
         if (cut < len) begin
            ncs = 1'b1;
            tick();
            check("cut_xfer_done", xfer_done, 1'b0);
            check("cut_busy", busy, 1'b0);
            return;
         end
         check("wr_xfer_done", xfer_done, 1'b1);
         ok_m = 1'b1;
      end else begin
         check("dummy_oe", {dqs_oe, dq_oe}, 2'b10);
         dq_i = 8'($urandom);
         repeat (DUMMY) tick();
         for (int k = 0; k < len; k++) begin
            exp = (cmd == 4'h2) ? mem_m[idx_at(addr, size, k)] : status_exp();
            check((cmd == 4'h2) ? "rd_data" : "stat_data", {dq_oe, dqs_oe, dq_o},
                  {2'b11, exp});
            tick();
         end
         check("rd_xfer_done", xfer_done, 1'b1);
         if (cmd == 4'h2) ok_m = 1'b1;
      end
      ncs = 1'b1;
      tick();
      check("back_to_idle", {busy, dq_oe, dqs_oe, xfer_done}, 4'b0000);
   endtask

   task automatic status_read();
      xact(4'h5, 4'h0, 2, 32'h0, 2);
   endtask

   initial begin
      logic [31:0] addr;
      logic [3:0]  size;
      int unsigned len;

      reset = 1'b1;
      ncs   = 1'b1;
      dq_i  = 8'h00;
      @(negedge clk);
      tick();
      tick();
      check("reset_outputs", {dq_o, dq_oe, dqs_oe, busy, xfer_done, cmd_err}, 32'h0);
      reset = 1'b0;
      tick();
      status_read();

      // Write then read back a short linear burst
      pend = '{8'h11, 8'h22, 8'h33, 8'h44};
      xact(4'hA, 4'h0, 4, 32'h100, 4);
      xact(4'h2, 4'h0, 4, 32'h100, 4);

      // Linear burst wrapping over the top of the RAM
      xact(4'hA, 4'h0, 2, DEPTH - 1, 2);
      xact(4'h2, 4'h0, 1, 32'h0, 1);
      xact(4'h2, 4'h0, 2, DEPTH - 1, 2);
      status_read();

      // 8-byte wrap window, two passes
      pend = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
      xact(4'hA, 4'h0, 8, 32'h200, 8);
      xact(4'h2, 4'h1, 10, 32'h206, 10);

      // Unknown command
      xact(4'h7, 4'h0, 4, 32'h0, 4);
      status_read();

      // Write truncated after 3 of 8 bytes
      xact(4'hA, 4'h0, 8, 32'h300, 3);
      status_read();
      xact(4'h2, 4'h0, 3, 32'h300, 3);

      // Zero length and out-of-range address
      xact(4'hA, 4'h0, 0, 32'h400, 0);
      status_read();
      xact(4'hA, 4'h0, 2, 32'h0004_0010, 2);
      status_read();
      xact(4'h2, 4'h0, 2, 32'h10, 2);

      // Reset in the middle of a read burst
      send_hdr(4'h2, 4'h0, 4, 32'h100);
      repeat (DUMMY) tick();
      check("pre_reset_data", dq_o, mem_m[32'h100]);
      tick();
      reset = 1'b1;
      tick();
      check("reset_mid_read", {dq_o, dq_oe, dqs_oe, busy, xfer_done, cmd_err}, 32'h0);
      reset   = 1'b0;
      ncs     = 1'b1;
      range_m = 1'b0;
      err_m   = 1'b0;
      ok_m    = 1'b0;
      tick();
      status_read();
      xact(4'h2, 4'h0, 4, 32'h100, 4);

      // Randomized write/read-back pairs with random size codes
      for (int it = 0; it < 10; it++) begin
         addr = $urandom_range(0, DEPTH - 1);
         if ($urandom_range(0, 3) == 0) addr = addr | 32'h0100_0000;
         size = 4'($urandom_range(0, 15));
         len  = $urandom_range(1, 12);
         xact(4'hA, size, len, addr, len);
         status_read();
         xact(4'h2, size, len, addr, len);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ospi_target_ram.md
# ospi_target_ram

Parametrised octal-SPI target with on-chip byte RAM, replacing the fixed-width, fixed-timing target. It decodes an 8-byte command header from the host, then runs a write burst, a read burst (linear or wrapping) or a status read against an internal RAM of `2**ADDR_W` bytes. It sits behind the top-level pad buffers. It sees only split `dq_i`/`dq_o`/`dq_oe` and `dqs_oe`; the top level forms DQS from the inverted clock.

## Interface
- `DQ_W`, 8: bus width per clock; header and data are bytes, so `DQ_W` must equal 8 (4-bit mode reserved, elaborate-time error otherwise)
- `ADDR_W`, 18: RAM address width; depth `2**ADDR_W` bytes
- `LEN_W`, 24: transfer-length field width; must be ≤ 24
- `DUMMY`, 2: dummy cycles before read data; must be ≥ 1 (covers RAM read latency)
- `clk` in 1: single clock; host drives DQ synchronously, all sampling on rising edge
- `reset` in 1: synchronous, active-high
- `ncs` in 1: chip select, active low, sampled on `clk`
- `dq_i` in DQ_W: data from pads
- `dq_o` out DQ_W: data to pads, registered
- `dq_oe` out 1: drive enable for DQ
- `dqs_oe` out 1: drive enable for DQS
- `busy` out 1: transaction in progress (state ≠ IDLE)
- `xfer_done` out 1: one-cycle pulse when the data phase completes with its full length
- `cmd_err` out 1: one-cycle pulse on an unknown command code

## Operation
- Header, bytes 0..7 on consecutive cycles with `ncs` low:
  - byte 0 = `{cmd[3:0], size[3:0]}`
  - bytes 1..3 = len, MSB first
  - bytes 4..7 = address, MSB first
- Commands: `0xA` write, `0x2` read, `0x5` status read. Any other code pulses `cmd_err`, sets `status[1]` and enters DONE.
- Address: the RAM index is `addr[ADDR_W-1:0]`. If any of `addr[31:ADDR_W]` is nonzero, set `status[2]` (range); the transfer still proceeds.
- `size` = 0: linear burst; the address increments modulo `2**ADDR_W`.
- `size` = n in 1..7: wrap burst; the low `n+2` address bits increment and wrap, and the upper bits hold.
- `size` > 7: treated as 7.
- Data phase length: exactly `len` bytes, counted by a full `LEN_W`-bit counter. `len` = 0 skips the data phase and goes to DONE without a `xfer_done` pulse.
- Write: each data cycle writes `dq_i` into `ram[idx]`, then the address advances.
- Read: each data cycle drives `ram[idx]` on `dq_o`.
- Status read: after the dummy cycles, drives `status` for each of the `len` bytes.
  - `status` = `{5'b0, range, cmd_err, last_xfer_ok}`.
  - `status` is cleared on `reset` and on the first byte of any non-status command.
- DONE: all further bytes are ignored until `ncs` rises.
- `ncs` high in any state: next state is IDLE. No RAM write occurs in that cycle. A truncated burst leaves `last_xfer_ok` = 0. Pending outputs are dropped.
- States and transitions:
  - IDLE → HDR when `ncs` is low. The byte sampled in that same cycle is header byte 0.
  - HDR → (byte 7): WDATA for write, DUMMY for read or status, DONE for an unknown command or `len` = 0.
  - DUMMY → after `DUMMY` cycles: RDATA or STAT.
  - WDATA / RDATA / STAT → DONE after `len` bytes.
  - DONE → IDLE when `ncs` goes high.

## Timing
- Reset values: `dq_o`=0, `dq_oe`=0, `dqs_oe`=0, `busy`=0, `xfer_done`=0, `cmd_err`=0, `status`=0.
- Header: 8 cycles. Write data starts in the cycle after header byte 7.
- Read timing:
  - `dqs_oe` goes high in the first DUMMY cycle and stays high until `ncs` rises.
  - `dq_oe` goes high in the first RDATA/STAT cycle and stays high until `ncs` rises.
  - `dq_o` holds data byte k in data cycle k.
- RAM: synchronous read. The implementation issues the read one cycle ahead (during the last DUMMY cycle for byte 0).
- Write: RAM write occurs at the end of the data cycle in which the byte is sampled.
- `xfer_done`: asserted in the cycle after the last data byte.
- `cmd_err`: asserted in the cycle after header byte 0.
- `reset` has priority over `ncs` and aborts any state to IDLE.

## Structure
- Shared package `ospi_pkg`:
  - command codes `OSPI_CMD_WRITE`/`READ`/`STATUS`
  - `HDR_LEN` = 8
  - state enum
  - status bit indices
- One sub-module, `ospi_ram`: a single-port byte RAM with `ADDR_W` parameter, sync write, and 1-cycle sync read, so it infers block RAM.
- The FSM, counters and address generator live in `ospi_target_ram`.

## Test plan
- Write `0xA0`, len=4, addr=0x100, data 11 22 33 44, then read `0x20` same header → after 2 dummy cycles, `dq_o` = 11 22 33 44 with `dq_oe`=1; `xfer_done` pulses once per transaction.
- Linear wrap at top: write 2 bytes at addr=`2**ADDR_W-1` → bytes land at `2**ADDR_W-1` and 0; `status[2]`=0.
- Wrap burst: read `0x21` (size=1, 8-byte wrap), len=10, addr=0x206 → indices 206,207,200,…,207 (two passes over the 8-byte window).
- Unknown command `0x70` → `cmd_err` pulse; status read afterwards returns `0x02`; no `dq_oe` during the bad transaction.
- `ncs` raised after 3 of 8 write bytes → 3 RAM bytes written, no `xfer_done`, state IDLE next cycle; status read returns bit0=0.
- `reset` asserted during RDATA → all outputs at reset values in the next cycle; RAM contents unchanged.
